// File: rtl/register_file.sv
// +--------------------------------------------------------------------------+
// | register_file : 32 x N register bank, one write port, two read ports,    |
// |                 register 0 hardwired to zero, optional write-through.    |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module register_file #(
    parameter int N      = 32,
    parameter bit BYPASS = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_ena,
    input  logic [4:0]   wr_addr,
    input  logic [N-1:0] wr_data,
    input  logic [4:0]   rd_addr0,
    output logic [N-1:0] rd_data0,
    input  logic [4:0]   rd_addr1,
    output logic [N-1:0] rd_data1
);

    localparam logic [4:0] c_zero_addr = 5'd0;

    logic [31:1]  w_we;
    logic [N-1:0] w_regs [0:31];
    logic         w_fwd0;
    logic         w_fwd1;

    // Slot 0 of the read view is a constant; no flop exists behind it.
    assign w_regs[0] = '0;

    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_reg
            logic [N-1:0] r_reg;

            assign w_we[gi] = wr_ena & (wr_addr == 5'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_reg <= '0;
                end else if (w_we[gi]) begin
                    r_reg <= wr_data;
                end
            end

            assign w_regs[gi] = r_reg;
        end
    endgenerate

    // Forwarding is suppressed in reset so every read is zero while rst_n is low.
    assign w_fwd0 = BYPASS && rst_n && wr_ena && (wr_addr == rd_addr0) && (rd_addr0 != c_zero_addr);
    assign w_fwd1 = BYPASS && rst_n && wr_ena && (wr_addr == rd_addr1) && (rd_addr1 != c_zero_addr);

    always_comb begin
        rd_data0 = w_regs[rd_addr0];
        rd_data1 = w_regs[rd_addr1];
        if (w_fwd0) begin
            rd_data0 = wr_data;
        end
        if (w_fwd1) begin
            rd_data1 = wr_data;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_register_file.sv
// +--------------------------------------------------------------------------+
// | tb_register_file : directed self-checking bench for register_file,       |
// |                    one instance per BYPASS setting on shared inputs.     |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_register_file;

    logic        clk;
    logic        rst_n;
    logic        wr_ena;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr0;
    logic [4:0]  rd_addr1;
    logic [31:0] a_rd0, a_rd1;   // BYPASS = 0
    logic [31:0] b_rd0, b_rd1;   // BYPASS = 1

    logic [31:0] model [0:31];
    int          n_pass;
    int          n_total;

    register_file #(.N(32), .BYPASS(1'b0)) u_dut_nb (
        .clk(clk), .rst_n(rst_n), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr0(rd_addr0), .rd_data0(a_rd0), .rd_addr1(rd_addr1), .rd_data1(a_rd1)
    );

    register_file #(.N(32), .BYPASS(1'b1)) u_dut_bp (
        .clk(clk), .rst_n(rst_n), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr0(rd_addr0), .rd_data0(b_rd0), .rd_addr1(rd_addr1), .rd_data1(b_rd1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst_n    = 1'b0;
        wr_ena   = 1'b1;
        wr_addr  = 5'd3;
        wr_data  = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int a = 0; a < 32; a++) begin
            rd_addr0 = 5'(a);
            rd_addr1 = 5'(31 - a);
            #1;
            n_total++;
            if (a_rd0 !== 32'h0) $display("FAIL reset_rd0 addr=%0d got=%h exp=%h", a, a_rd0, 32'h0);
            else n_pass++;
            n_total++;
            if (a_rd1 !== 32'h0) $display("FAIL reset_rd1 addr=%0d got=%h exp=%h", 31 - a, a_rd1, 32'h0);
            else n_pass++;
            n_total++;
            if (b_rd0 !== 32'h0) $display("FAIL reset_bp_rd0 addr=%0d got=%h exp=%h", a, b_rd0, 32'h0);
            else n_pass++;
            n_total++;
            if (b_rd1 !== 32'h0) $display("FAIL reset_bp_rd1 addr=%0d got=%h exp=%h", 31 - a, b_rd1, 32'h0);
            else n_pass++;
        end
        wr_ena = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    task automatic test_fill;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            wr_ena   = 1'b1;
            wr_addr  = 5'(i);
            wr_data  = 32'hA5A5_0000 + 32'(i);
            model[i] = 32'hA5A5_0000 + 32'(i);
        end
        @(negedge clk);
        wr_ena = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rd_addr0 = 5'(a);
            rd_addr1 = 5'(a);
            #1;
            n_total++;
            if (a_rd0 !== model[a]) $display("FAIL fill_rd0 addr=%0d got=%h exp=%h", a, a_rd0, model[a]);
            else n_pass++;
            n_total++;
            if (a_rd1 !== model[a]) $display("FAIL fill_rd1 addr=%0d got=%h exp=%h", a, a_rd1, model[a]);
            else n_pass++;
            n_total++;
            if (b_rd0 !== model[a]) $display("FAIL fill_bp_rd0 addr=%0d got=%h exp=%h", a, b_rd0, model[a]);
            else n_pass++;
        end
    endtask

    task automatic test_zero_reg;
        @(negedge clk);
        wr_ena   = 1'b1;
        wr_addr  = 5'd0;
        wr_data  = 32'hDEAD_BEEF;
        rd_addr0 = 5'd0;
        rd_addr1 = 5'd0;
        #1;
        n_total++;
        if (b_rd0 !== 32'h0) $display("FAIL zero_nobypass got=%h exp=%h", b_rd0, 32'h0);
        else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if (a_rd0 !== 32'h0) $display("FAIL zero_after_edge got=%h exp=%h", a_rd0, 32'h0);
        else n_pass++;
        n_total++;
        if (b_rd1 !== 32'h0) $display("FAIL zero_bp_after_edge got=%h exp=%h", b_rd1, 32'h0);
        else n_pass++;
        @(negedge clk);
        wr_ena = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rd_addr0 = 5'(a);
            rd_addr1 = 5'(31 - a);
            #1;
            n_total++;
            if (a_rd0 !== model[a]) $display("FAIL zero_readback addr=%0d got=%h exp=%h", a, a_rd0, model[a]);
            else n_pass++;
            n_total++;
            if (a_rd1 !== model[31 - a]) $display("FAIL zero_readback1 addr=%0d got=%h exp=%h", 31 - a, a_rd1, model[31 - a]);
            else n_pass++;
        end
    endtask

    task automatic test_wr_gate;
        @(negedge clk);
        wr_ena   = 1'b0;
        wr_addr  = 5'd7;
        wr_data  = 32'hFFFF_FFFF;
        rd_addr0 = 5'd7;
        rd_addr1 = 5'd8;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            n_total++;
            if (a_rd0 !== 32'hA5A5_0007) $display("FAIL gate_rd0 cyc=%0d got=%h exp=%h", c, a_rd0, 32'hA5A5_0007);
            else n_pass++;
            n_total++;
            if (b_rd0 !== 32'hA5A5_0007) $display("FAIL gate_bp_rd0 cyc=%0d got=%h exp=%h", c, b_rd0, 32'hA5A5_0007);
            else n_pass++;
        end
        @(negedge clk);
        wr_addr = 5'bxxxxx;
        @(posedge clk);
        #1;
        n_total++;
        if (a_rd1 !== 32'hA5A5_0008) $display("FAIL gate_xaddr got=%h exp=%h", a_rd1, 32'hA5A5_0008);
        else n_pass++;
        @(negedge clk);
        wr_addr = 5'd0;
    endtask

    task automatic test_collision;
        @(negedge clk);
        rd_addr0 = 5'd5;
        rd_addr1 = 5'd5;
        wr_ena   = 1'b1;
        wr_addr  = 5'd5;
        wr_data  = 32'h1234_5678;
        #1;
        n_total++;
        if (a_rd0 !== 32'hA5A5_0005) $display("FAIL coll_pre_rd0 got=%h exp=%h", a_rd0, 32'hA5A5_0005);
        else n_pass++;
        n_total++;
        if (a_rd1 !== 32'hA5A5_0005) $display("FAIL coll_pre_rd1 got=%h exp=%h", a_rd1, 32'hA5A5_0005);
        else n_pass++;
        n_total++;
        if (b_rd0 !== 32'h1234_5678) $display("FAIL coll_bp_rd0 got=%h exp=%h", b_rd0, 32'h1234_5678);
        else n_pass++;
        n_total++;
        if (b_rd1 !== 32'h1234_5678) $display("FAIL coll_bp_rd1 got=%h exp=%h", b_rd1, 32'h1234_5678);
        else n_pass++;
        @(posedge clk);
        #1;
        model[5] = 32'h1234_5678;
        n_total++;
        if (a_rd0 !== 32'h1234_5678) $display("FAIL coll_post_rd0 got=%h exp=%h", a_rd0, 32'h1234_5678);
        else n_pass++;
        n_total++;
        if (a_rd1 !== 32'h1234_5678) $display("FAIL coll_post_rd1 got=%h exp=%h", a_rd1, 32'h1234_5678);
        else n_pass++;
        @(negedge clk);
        wr_ena = 1'b0;
    endtask

    task automatic test_back_to_back;
        rd_addr0 = 5'd31;
        rd_addr1 = 5'd30;
        for (int v = 1; v <= 3; v++) begin
            @(negedge clk);
            wr_ena  = 1'b1;
            wr_addr = 5'd31;
            wr_data = 32'(v);
            #1;
            n_total++;
            if (a_rd0 !== model[31]) $display("FAIL b2b_pre v=%0d got=%h exp=%h", v, a_rd0, model[31]);
            else n_pass++;
            n_total++;
            if (b_rd0 !== 32'(v)) $display("FAIL b2b_bp v=%0d got=%h exp=%h", v, b_rd0, 32'(v));
            else n_pass++;
            @(posedge clk);
            #1;
            model[31] = 32'(v);
            n_total++;
            if (a_rd0 !== 32'(v)) $display("FAIL b2b_post v=%0d got=%h exp=%h", v, a_rd0, 32'(v));
            else n_pass++;
            n_total++;
            if (a_rd1 !== 32'hA5A5_001E) $display("FAIL b2b_reg30 v=%0d got=%h exp=%h", v, a_rd1, 32'hA5A5_001E);
            else n_pass++;
        end
        @(negedge clk);
        wr_ena = 1'b0;
    endtask

    task automatic test_async_reset;
        rd_addr0 = 5'd5;
        rd_addr1 = 5'd31;
        @(posedge clk);
        #3;
        n_total++;
        if (a_rd0 !== 32'h1234_5678) $display("FAIL async_preload got=%h exp=%h", a_rd0, 32'h1234_5678);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (a_rd0 !== 32'h0) $display("FAIL async_rd0 got=%h exp=%h", a_rd0, 32'h0);
        else n_pass++;
        n_total++;
        if (a_rd1 !== 32'h0) $display("FAIL async_rd1 got=%h exp=%h", a_rd1, 32'h0);
        else n_pass++;
        n_total++;
        if (b_rd1 !== 32'h0) $display("FAIL async_bp_rd1 got=%h exp=%h", b_rd1, 32'h0);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        wr_ena  = 1'b1;
        wr_addr = 5'd31;
        wr_data = 32'h0BAD_F00D;
        @(posedge clk);
        #1;
        n_total++;
        if (a_rd1 !== 32'h0BAD_F00D) $display("FAIL release_first_write got=%h exp=%h", a_rd1, 32'h0BAD_F00D);
        else n_pass++;
        n_total++;
        if (a_rd0 !== 32'h0) $display("FAIL release_reg5 got=%h exp=%h", a_rd0, 32'h0);
        else n_pass++;
        @(negedge clk);
        wr_ena = 1'b0;
    endtask

    initial begin
        n_pass   = 0;
        n_total  = 0;
        rst_n    = 1'b0;
        wr_ena   = 1'b0;
        wr_addr  = 5'd0;
        wr_data  = 32'h0;
        rd_addr0 = 5'd0;
        rd_addr1 = 5'd0;
        test_reset();
        test_fill();
        test_zero_reg();
        test_wr_gate();
        test_collision();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/register_file.md
Name: register_file

Overview:
- 32-entry x N-bit register bank: the write-side counterpart of the 32:1 read-select mux.
- A 5-bit write address is decoded one-hot into 32 per-register write enables, routing one data word to exactly one register per clock.
- Two independent 32:1 read ports return register contents.
- Sits in the CPU datapath between writeback (write port) and decode (read ports). Register 0 is hardwired to zero.

Parameters:
- N, 32, data width of every register and port.
- BYPASS, 0: 1 = write-through forwarding from the write port to the read ports in the same cycle; 0 = reads return the pre-write value.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous active-low reset.
- wr_ena  input  1  write enable.
- wr_addr  input  5  destination register index.
- wr_data  input  N  data to write.
- rd_addr0  input  5  read port 0 index.
- rd_data0  output  N  read port 0 data.
- rd_addr1  input  5  read port 1 index.
- rd_data1  output  N  read port 1 data.

Behaviour:
- State: regs[1..31], each N bits. No storage exists for reg 0.
- Reset: rst_n low forces all regs[1..31] to 0 immediately, with no clock required. While rst_n is low, writes are ignored.
  - Release is synchronous in effect: the first write can land on the first rising edge with rst_n high.
- Write decode:
  - decoded one-hot enable we[i] = wr_ena & (wr_addr == i), for i in 1..31.
  - At most one register updates per edge.
  - wr_addr == 0 with wr_ena = 1 is accepted and discarded: no state change.
  - wr_ena = 0: no register changes regardless of wr_addr or wr_data.
- Write latency: the value is stored at the rising edge where wr_ena = 1. It is visible on the read ports from that edge onward (same-cycle visibility only if BYPASS = 1).
- Read ports:
  - Purely combinational from rd_addrX and register state; zero-cycle latency.
  - rd_dataX = 0 whenever rd_addrX == 0, regardless of writes.
  - During reset, rd_dataX = 0 for all addresses.
- Read/write collision (rd_addrX == wr_addr != 0, wr_ena = 1):
  - BYPASS = 0: rd_dataX shows the old value until the edge, then the new value.
  - BYPASS = 1: rd_dataX = wr_data combinationally in that cycle.
  - Address 0 is never bypassed.
- Both read ports may address the same register and return identical data.
- X/unknown on wr_addr while wr_ena = 0 must not corrupt state.
- Reset asserted mid-write, coincident with the edge: reset wins and the register reads 0.

Test Plan:
1. Reset: hold rst_n = 0 for 2 cycles, then sweep rd_addr0 over 0..31 -> every read returns 0. Assert rst_n low asynchronously between edges after loading data -> reads drop to 0 with no clock edge.
2. Fill/readback: write regs i = 1..31 with 32'hA5A5_0000 + i, one per cycle. Read both ports over all addresses -> rd_data = 32'hA5A5_0000 + i; address 0 returns 0.
3. Zero register: write 32'hDEAD_BEEF to addr 0 -> rd_data0 at addr 0 stays 0, and no other register changes (full readback matches scenario 2).
4. Write enable gating: wr_ena = 0, wr_addr = 7, wr_data = 32'hFFFF_FFFF for 5 cycles -> reg 7 keeps its prior value 32'hA5A5_0007.
5. Collision: rd_addr0 = rd_addr1 = 5, wr_ena = 1, wr_addr = 5, wr_data = 32'h1234_5678.
   - BYPASS = 0: both ports read 32'hA5A5_0005 before the edge and 32'h1234_5678 after it.
   - BYPASS = 1: both ports read 32'h1234_5678 in the same cycle.
6. Back-to-back writes to reg 31 (values 1, 2, 3 on consecutive edges) -> reads 1, 2, 3 cycle by cycle; reg 30 is unchanged.
